// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: IDLE -> EXEC -> RESP.
// Define ALU_ARB_RR_EN for round-robin contention; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_op1,
  input  logic [XLEN-1:0] req0_op2,
  input  logic [3:0]      req0_func,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_op1,
  input  logic [XLEN-1:0] req1_op2,
  input  logic [3:0]      req1_func,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic [3:0]      alu_func,
  input  logic [XLEN-1:0] alu_out,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_data
);

  localparam int unsigned FW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [FW-1:0]   r_func;
  logic            r_id;
  logic [XLEN-1:0] r_rsp_data;
  logic            r_rsp_id;
  logic            r_rsp_valid;
  logic            w_gnt_valid;
  logic            w_gnt_id;
  logic            w_accept;
  logic            w_capture;

  assign w_gnt_valid = req0_valid | req1_valid;

`ifdef ALU_ARB_RR_EN
  logic r_last;

  // Reset value 1 hands the first contention to requester 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_gnt_id;
    end
  end

  assign w_gnt_id = (req0_valid && req1_valid) ? ~r_last : req1_valid;
`else
  assign w_gnt_id = ~req0_valid & req1_valid;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake strobes
  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_accept    = 1'b1;
          req0_ready  = ~w_gnt_id;
          req1_ready  = w_gnt_id;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op1       <= '0;
      r_op2       <= '0;
      r_func      <= '0;
      r_id        <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= (w_state_nxt == RESP);
      if (w_accept) begin
        r_op1  <= w_gnt_id ? req1_op1  : req0_op1;
        r_op2  <= w_gnt_id ? req1_op2  : req0_op2;
        r_func <= w_gnt_id ? req1_func : req0_func;
        r_id   <= w_gnt_id;
      end
      if (w_capture) begin
        r_rsp_data <= alu_out;
        r_rsp_id   <= r_id;
      end
    end
  end

  assign alu_op1   = r_op1;
  assign alu_op2   = r_op2;
  assign alu_func  = r_func;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: acceptance model pushes expected results, monitor pops them.
`timescale 1ns/1ps
module tb_alu_arbiter;

  localparam int unsigned XLEN = 32;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [XLEN-1:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic [3:0]      req0_func = '0, req1_func = '0;
  logic [XLEN-1:0] alu_op1, alu_op2, alu_out, rsp_data;
  logic [3:0]      alu_func;
  logic            rsp_valid, rsp_id;
  logic            rsp_ready = 1'b0;

  typedef struct packed {
    logic            id;
    logic [XLEN-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   grant_log[$];
  int   n_acc = 0;
  int   acc_neg = 0;
  int   negcount = 0;
  int   checks = 0;
  int   failures = 0;
  logic tb_last = 1'b1;
  logic win;
  exp_t e;

  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_func(req0_func),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_func(req1_func),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_func(alu_func), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] f, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    case (f)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
      default:  return ~(a ^ b);
    endcase
  endfunction

  // The shared ALU itself lives in the environment
  assign alu_out = ref_alu(alu_func, alu_op1, alu_op2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Acceptance model: decides who should win from the arbitration rules and records the expected result
  always @(posedge clk) begin
    #3;
    if (!rst_n) begin
      tb_last = 1'b1;
    end else if (sb_q.size() != 0) begin
      chk("ready_while_busy", 32'({req1_ready, req0_ready}), 32'd0);
    end else if (req0_valid || req1_valid) begin
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
        win = (tb_last == 1'b0);
`else
        win = 1'b0;
`endif
      end else begin
        win = req1_valid;
      end
      chk("grant", 32'({req1_ready, req0_ready}), win ? 32'd2 : 32'd1);
      if (req0_ready || req1_ready) grant_log.push_back(req1_ready ? 1 : 0);
      e.id   = win;
      e.data = win ? ref_alu(req1_func, req1_op1, req1_op2) : ref_alu(req0_func, req0_op1, req0_op2);
      sb_q.push_back(e);
      acc_neg = negcount;
      n_acc++;
      tb_last = win;
    end else begin
      chk("ready_no_request", 32'({req1_ready, req0_ready}), 32'd0);
    end
  end

  // Response monitor: checks timing, payload and stability, pops on handshake
  always @(negedge clk) begin
    negcount++;
    if (!rst_n) begin
      sb_q.delete();
    end else if (sb_q.size() == 0) begin
      chk("no_spurious_rsp", 32'(rsp_valid), 32'd0);
    end else begin
      chk("rsp_valid_timing", 32'(rsp_valid), 32'((negcount - acc_neg) >= 3));
      if (rsp_valid) begin
        chk("rsp_id", 32'(rsp_id), 32'(sb_q[0].id));
        chk("rsp_data", rsp_data, sb_q[0].data);
        if (rsp_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic drive(input int id, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [3:0] f);
    if (id == 0) begin
      req0_valid = 1'b1; req0_op1 = a; req0_op2 = b; req0_func = f;
    end else begin
      req1_valid = 1'b1; req1_op1 = a; req1_op2 = b; req1_func = f;
    end
  endtask

  task automatic undrive(input int id);
    if (id == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (n_acc < target && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", 32'(n_acc >= target), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic send(input int id, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [3:0] f);
    int target;
    target = n_acc + 1;
    drive(id, a, b, f);
    wait_acc(target);
    undrive(id);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_alu_op1"}, alu_op1, 32'd0);
    chk({tag, "_alu_op2"}, alu_op2, 32'd0);
    chk({tag, "_alu_func"}, 32'(alu_func), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_ready"}, 32'({req1_ready, req0_ready}), 32'd0);
  endtask

  function automatic logic [XLEN-1:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      2:       return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int gbase;
    int g;
    int exp_g[4];
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // Single request and wrap-around subtraction
    send(0, 32'd5, 32'd7, ALU_ADD);
    send(1, 32'd0, 32'd1, ALU_SUB);

    // Contention: both held valid for four grants
    base  = n_acc;
    gbase = grant_log.size();
    drive(0, 32'd100, 32'd23, ALU_ADD);
    drive(1, 32'h0000_F0F0, 32'h0000_0FF0, ALU_XOR);
    wait_acc(base + 4);
    undrive(0);
    undrive(1);
`ifdef ALU_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      g = (grant_log.size() > gbase + i) ? grant_log[gbase + i] : -1;
      chk("contention_order", 32'(g), 32'(exp_g[i]));
    end
    wait_idle();

    // Backpressure with a competing request waiting
    rsp_ready = 1'b0;
    send(0, 32'hFFFF_0000, 32'h1234_5678, ALU_AND);
    base = n_acc;
    drive(1, 32'd9, 32'd3, ALU_SLL);
    repeat (7) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    wait_acc(base + 1);
    undrive(1);
    wait_idle();

    // Reset while the operation is in EXEC
    send(0, 32'd11, 32'd22, ALU_ADD);
    #1;
    rst_n = 1'b0;
    undrive(0);
    #1;
    check_zero("reset_mid_op");
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    send(0, 32'h0000_00F0, 32'h0000_000F, ALU_OR);
    wait_idle();

    // Randomized traffic, including requests withdrawn before acceptance
    for (int c = 0; c < 300; c++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req0_op1   = rand_operand();
      req0_op2   = rand_operand();
      req0_func  = 4'($urandom_range(0, 15));
      req1_valid = 1'($urandom_range(0, 1));
      req1_op1   = rand_operand();
      req1_op2   = rand_operand();
      req1_func  = 4'($urandom_range(0, 15));
      rsp_ready  = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    undrive(0);
    undrive(1);
    rsp_ready = 1'b1;
    wait_idle();
    chk("random_accepts_seen", 32'(n_acc > 20), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width.
REQ-002 Clock and reset ports: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-003 Requester 0 ports:
- req0_valid  in  1  request present.
- req0_ready  out  1  request accepted this cycle when high with req0_valid.
- req0_op1  in  XLEN  operand 1.
- req0_op2  in  XLEN  operand 2.
- req0_func  in  4  ALU function code (ALU_* encodings from defines.vh).
REQ-004 Requester 1 ports: req1_valid, req1_ready, req1_op1, req1_op2, req1_func; same directions, widths and meanings as requester 0.
REQ-005 Shared-ALU ports:
- alu_op1  out  XLEN  operand 1 to the ALU.
- alu_op2  out  XLEN  operand 2 to the ALU.
- alu_func  out  4  function to the ALU.
- alu_out  in  XLEN  combinational ALU result.
REQ-006 Response ports:
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  index of the requester that owns the result.
- rsp_data  out  XLEN  result.

Function
REQ-007 The block SHALL implement an FSM with states IDLE, EXEC and RESP, and SHALL be in IDLE after reset.
REQ-008 reqN_ready SHALL be high only in IDLE and only for the granted requester; both SHALL be low in EXEC and RESP.
REQ-009 In IDLE, with exactly one reqN_valid high, that requester SHALL be granted.
REQ-010 In IDLE, with both valid, the grant SHALL follow the arbitration policy of REQ-021.
REQ-011 On acceptance, the block SHALL latch op1, op2, func and the grant index, and SHALL move to EXEC.
REQ-012 alu_op1, alu_op2 and alu_func SHALL be driven from the latched registers in every state; they SHALL be 0 after reset.
REQ-013 In EXEC, the block SHALL capture alu_out into rsp_data and the latched index into rsp_id at the next edge, and SHALL move to RESP.
REQ-014 rsp_valid SHALL be high only in RESP; rsp_data and rsp_id SHALL stay stable while rsp_valid is high and rsp_ready is low.
REQ-015 In RESP with rsp_ready high, the block SHALL return to IDLE; rsp_ready SHALL be ignored outside RESP.
REQ-016 Latency: acceptance at edge N gives rsp_valid high after edge N+1; minimum issue interval is 3 cycles.
REQ-017 func SHALL be passed through unmodified; undefined codes produce whatever alu_out presents, and no error is flagged.
REQ-018 Arithmetic SHALL be XLEN bits wrapping; the block SHALL NOT alter carries or overflow.
REQ-019 A request deasserted before acceptance SHALL be dropped without side effects.

Reset
REQ-020 Asserting rst_n low in any state SHALL immediately force:
- state IDLE;
- rsp_valid, rsp_id and rsp_data to 0;
- the latched operands and function to 0;
- the last-grant register to 1.
Any in-flight operation SHALL be discarded, with no response after release.

Configuration
REQ-021 Macro ALU_ARB_RR_EN selects the arbitration policy:
- Defined: round-robin. On contention, the requester not granted last SHALL win. The last-grant register updates on each acceptance. The first contention after reset goes to requester 0.
- Undefined: fixed priority. Requester 0 always wins contention, and the last-grant register is not implemented.

Verification
REQ-022 Single request: req0 ALU_ADD op1=5, op2=7, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_data=12, rsp_id=0, then IDLE.
REQ-023 Wrap: req1 ALU_SUB op1=0, op2=1 -> rsp_data=0xFFFFFFFF, rsp_id=1.
REQ-024 Contention: both valid continuously for 4 ops:
- with ALU_ARB_RR_EN, grant order is 0,1,0,1;
- without it, grant order is 0,0,0,0.
REQ-025 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, both reqN_ready=0; accept occurs the cycle after rsp_ready=1.
REQ-026 Reset mid-op: rst_n low during EXEC -> all outputs 0 immediately, IDLE after release, no response emitted; the next req0 ALU_OR 0xF0|0x0F gives 0xFF.
